sa_shift_add: RTL and testbench



---
 rtl/sa_shift_add_if.sv | 23 ++
 rtl/sa_shift_add.sv | 51 +++++
 tb/tb_sa_shift_add.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sa_shift_add_if.sv
// sa_shift_add_if: partial-sum beat input and result output handshake bundle for sa_shift_add
interface sa_shift_add_if #(
  parameter int N_ELEM_OUT  = 256,
  parameter int BIT_ADC     = 4,
  parameter int N_BIT_INPUT = 4
);
  logic clear_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [N_ELEM_OUT*BIT_ADC-1:0] psum_i;
  logic [$clog2(N_BIT_INPUT)-1:0] bit_idx_o;
  logic out_valid_o;
  logic out_ready_i;
  logic [N_ELEM_OUT*(BIT_ADC+N_BIT_INPUT)-1:0] result_o;
  modport master (
    output clear_i, in_valid_i, psum_i, out_ready_i,
    input  in_ready_o, bit_idx_o, out_valid_o, result_o
  );
  modport slave (
    input  clear_i, in_valid_i, psum_i, out_ready_i,
    output in_ready_o, bit_idx_o, out_valid_o, result_o
  );
endinterface

// File: rtl/sa_shift_add.sv
// sa_shift_add: bit-serial MSB-first shift-and-add column accumulator with one-deep result buffer
module sa_shift_add #(
  parameter int N_ELEM_OUT  = 256,
  parameter int BIT_ADC     = 4,
  parameter int N_BIT_INPUT = 4
) (
  input logic clk,
  input logic rst,
  sa_shift_add_if.slave bus
);
  localparam int ACC_W = BIT_ADC + N_BIT_INPUT;
  localparam int CW = $clog2(N_BIT_INPUT);
  logic [CW-1:0] cnt;
  logic [N_ELEM_OUT*ACC_W-1:0] acc, nxt, result;
  logic out_valid, last, ready, take;
  always_comb begin
    nxt = '0;
    last = cnt == CW'(N_BIT_INPUT - 1);
    ready = !bus.clear_i && !(last && out_valid && !bus.out_ready_i);
    take = bus.in_valid_i && ready;
    for (int k = 0; k < N_ELEM_OUT; k++)
      nxt[k*ACC_W +: ACC_W] = (cnt == '0 ? ACC_W'(0) : acc[k*ACC_W +: ACC_W] << 1)
                              + ACC_W'(bus.psum_i[k*BIT_ADC +: BIT_ADC]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      result <= '0;
      out_valid <= 1'b0;
    end else begin
      if (bus.clear_i) begin
        cnt <= '0;
        acc <= '0;
      end else if (take) begin
        acc <= nxt;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (take && last) begin
        result <= nxt;
        out_valid <= 1'b1;
      end else if (bus.out_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready_o = ready;
  assign bus.bit_idx_o = cnt;
  assign bus.out_valid_o = out_valid;
  assign bus.result_o = result;
endmodule

// File: tb/tb_sa_shift_add.sv
// tb_sa_shift_add: directed vector table plus reset and random-gap scoreboard sequences for sa_shift_add
module tb_sa_shift_add;
  typedef struct {
    logic clr;
    logic vld;
    logic [15:0] ps;
    logic ordy;
    logic rdy;
    logic [1:0] idx;
    logic ov;
    logic [31:0] res;
  } vec_t;
  logic clk, rst;
  int nchk, nfail, pushed, popped, mcnt;
  logic mov;
  logic [7:0] msum [4];
  logic [31:0] q [$];
  vec_t tv [27];
  sa_shift_add_if #(.N_ELEM_OUT(4), .BIT_ADC(4), .N_BIT_INPUT(4)) bus ();
  sa_shift_add #(.N_ELEM_OUT(4), .BIT_ADC(4), .N_BIT_INPUT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] pk(input logic [3:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  function automatic vec_t mk(input logic clr, vld, input logic [15:0] ps, input logic ordy, rdy,
                              input logic [1:0] idx, input logic ov, input logic [31:0] res);
    vec_t v;
    v = '{clr, vld, ps, ordy, rdy, idx, ov, res};
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic cycle(input logic vld, input logic ordy);
    logic take, lst;
    bus.clear_i = 1'b0;
    bus.in_valid_i = vld;
    bus.out_ready_i = ordy;
    bus.psum_i = 16'($urandom);
    #1;
    chk("t6_ready", 32'(bus.in_ready_o), 32'(!(mcnt == 3 && mov && !ordy)));
    chk("t6_valid", 32'(bus.out_valid_o), 32'(mov));
    if (bus.out_valid_o && ordy) begin
      if (q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL t6_dup actual=%h expected=no result", bus.result_o);
      end else begin
        chk("t6_result", bus.result_o, q.pop_front());
        popped++;
      end
    end
    lst = mcnt == 3;
    take = vld && !(lst && mov && !ordy);
    if (take) begin
      for (int k = 0; k < 4; k++) msum[k] += 8'(bus.psum_i[k*4 +: 4]) << (3 - mcnt);
      if (lst) begin
        q.push_back({msum[3], msum[2], msum[1], msum[0]});
        pushed++;
        for (int k = 0; k < 4; k++) msum[k] = '0;
      end
      mcnt = (mcnt + 1) % 4;
    end
    mov = (take && lst) ? 1'b1 : ordy ? 1'b0 : mov;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    tv[0]  = mk(0, 1, pk(1, 0, 0, 0), 1, 1, 1, 0, 32'h0);
    tv[1]  = mk(0, 1, pk(0, 0, 0, 0), 1, 1, 2, 0, 32'h0);
    tv[2]  = mk(0, 1, pk(1, 0, 0, 0), 1, 1, 3, 0, 32'h0);
    tv[3]  = mk(0, 1, pk(1, 0, 0, 0), 1, 1, 0, 1, 32'h0000000B);
    tv[4]  = mk(0, 1, pk(15, 15, 15, 15), 1, 1, 1, 0, 32'h0000000B);
    tv[5]  = mk(0, 1, pk(15, 15, 15, 15), 1, 1, 2, 0, 32'h0000000B);
    tv[6]  = mk(0, 1, pk(15, 15, 15, 15), 1, 1, 3, 0, 32'h0000000B);
    tv[7]  = mk(0, 1, pk(15, 15, 15, 15), 1, 1, 0, 1, 32'hE1E1E1E1);
    tv[8]  = mk(0, 1, pk(1, 15, 0, 0), 1, 1, 1, 0, 32'hE1E1E1E1);
    tv[9]  = mk(0, 1, pk(2, 0, 0, 0), 0, 1, 2, 0, 32'hE1E1E1E1);
    tv[10] = mk(0, 1, pk(3, 0, 0, 0), 0, 1, 3, 0, 32'hE1E1E1E1);
    tv[11] = mk(0, 1, pk(4, 0, 0, 0), 0, 1, 0, 1, 32'h0000781A);
    tv[12] = mk(0, 1, pk(1, 0, 1, 0), 0, 1, 1, 1, 32'h0000781A);
    tv[13] = mk(0, 1, pk(1, 0, 0, 0), 0, 1, 2, 1, 32'h0000781A);
    tv[14] = mk(0, 1, pk(1, 0, 0, 0), 0, 1, 3, 1, 32'h0000781A);
    tv[15] = mk(0, 1, pk(1, 1, 0, 0), 0, 0, 3, 1, 32'h0000781A);
    tv[16] = mk(0, 1, pk(1, 1, 0, 0), 0, 0, 3, 1, 32'h0000781A);
    tv[17] = mk(0, 1, pk(1, 1, 0, 0), 1, 1, 0, 1, 32'h0008010F);
    tv[18] = mk(0, 1, pk(3, 0, 0, 0), 0, 1, 1, 1, 32'h0008010F);
    tv[19] = mk(0, 1, pk(3, 0, 0, 0), 0, 1, 2, 1, 32'h0008010F);
    tv[20] = mk(1, 1, pk(7, 7, 7, 7), 0, 0, 0, 1, 32'h0008010F);
    tv[21] = mk(0, 1, pk(2, 2, 2, 2), 1, 1, 1, 0, 32'h0008010F);
    tv[22] = mk(0, 1, pk(2, 2, 2, 2), 0, 1, 2, 0, 32'h0008010F);
    tv[23] = mk(0, 1, pk(2, 2, 2, 2), 0, 1, 3, 0, 32'h0008010F);
    tv[24] = mk(0, 1, pk(2, 2, 2, 2), 0, 1, 0, 1, 32'h1E1E1E1E);
    tv[25] = mk(0, 0, pk(2, 2, 2, 2), 0, 1, 0, 1, 32'h1E1E1E1E);
    tv[26] = mk(1, 0, pk(0, 0, 0, 0), 0, 0, 0, 1, 32'h1E1E1E1E);
    nchk = 0;
    nfail = 0;
    rst = 1'b1;
    bus.clear_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.psum_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_idx", 32'(bus.bit_idx_o), 32'd0);
    chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
    for (int i = 0; i < 27; i++) begin
      bus.clear_i = tv[i].clr;
      bus.in_valid_i = tv[i].vld;
      bus.psum_i = tv[i].ps;
      bus.out_ready_i = tv[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.in_ready_o), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idx", i), 32'(bus.bit_idx_o), 32'(tv[i].idx));
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid_o), 32'(tv[i].ov));
      chk($sformatf("v%0d_result", i), bus.result_o, tv[i].res);
    end
    bus.clear_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.out_ready_i = 1'b0;
    bus.psum_i = pk(1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_pre_idx", 32'(bus.bit_idx_o), 32'd2);
    chk("t5_pre_valid", 32'(bus.out_valid_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("t5_idx", 32'(bus.bit_idx_o), 32'd0);
    chk("t5_valid", 32'(bus.out_valid_o), 32'd0);
    chk("t5_result", bus.result_o, 32'd0);
    mcnt = 0;
    mov = 1'b0;
    pushed = 0;
    popped = 0;
    for (int k = 0; k < 4; k++) msum[k] = '0;
    repeat (400) cycle($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)));
    repeat (4) cycle(1'b0, 1'b1);
    chk("t6_drain", 32'(q.size()), 32'd0);
    chk("t6_count", 32'(popped), 32'(pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
